exception_unit: RTL
===================

// Module: exception_unit
// PURPOSE
//  Trap/return sequencer feeding the machine-mode CSR file. Watches the MEM-stage instruction for
//  exceptions, MRET and a latched external interrupt, then picks one event by priority.
//  Drives the CSR file's is_trap/is_mret/mepc/mcause/mtval inputs for one cycle, flushes the
//  pipeline, and redirects fetch to mtvec (trap) or mepc (return).
// PARAMETERS
//  RESET_PC   32'h0000_0000  value of redirect_pc after reset (no redirect is issued)
//  INT_CAUSE  32'h8000_000B  mcause for the external interrupt (machine external, bit31=1)
// PORTS
//  clk           in   1   system clock
//  rst           in   1   asynchronous active-high reset
//  mstatus       in   32  CSR mstatus; only bit3 (MIE) is used
//  mtvec         in   32  CSR mtvec; direct mode, bits[1:0] ignored
//  mepc_i        in   32  CSR mepc readback (mepc_o of the CSR file)
//  valid_mem     in   1   MEM-stage slot holds a real (non-bubble) instruction
//  pc_mem        in   32  PC of the MEM-stage instruction
//  inst_mem      in   32  encoding of the MEM-stage instruction
//  addr_mem      in   32  data address of the MEM-stage load/store
//  illegal_inst  in   1   MEM instruction is illegal
//  ecall_m       in   1   MEM instruction is ECALL
//  l_fault       in   1   load access fault
//  s_fault       in   1   store access fault
//  mret          in   1   MEM instruction is MRET
//  interrupt     in   1   external interrupt request, level
//  is_trap       out  1   one-cycle pulse to the CSR file: take trap
//  is_mret       out  1   one-cycle pulse to the CSR file: return
//  mepc          out  32  trap PC to the CSR file
//  mcause        out  32  trap cause to the CSR file
//  mtval         out  32  trap value to the CSR file
//  csr_w_kill    out  1   suppresses the MEM-stage CSR write (CSR file gives csr_w priority over traps)
//  flush         out  1   flushes IF/ID/EX/MEM pipeline registers
//  redirect      out  1   fetch takes redirect_pc this cycle
//  redirect_pc   out  32  fetch target
// BEHAVIOUR
//  - Reset: state=IDLE, int_pend=0, every output 0, redirect_pc=RESET_PC. Reset during any state aborts the sequence.
//  - int_pend: set on any cycle interrupt=1. Cleared only when the interrupt event is accepted.
//  - Event detect (IDLE only, requires valid_mem=1). Priority high to low:
//      int_pend&MIE > illegal_inst > ecall_m > l_fault > s_fault > mret.
//    Cause codes: INT_CAUSE, 2, 11, 5, 7.
//    mtval: illegal -> inst_mem; l_fault/s_fault -> addr_mem; otherwise 0.
//    mepc = pc_mem for every trap; the interrupted instruction is squashed and re-executed.
//  - Accepting an event latches cause/pc/tval and a kind bit (trap vs mret), then moves IDLE->COMMIT.
//  - COMMIT, 1 cycle:
//    - Trap: is_trap=1. mret: is_mret=1 (the CSR file restores MIE).
//    - mepc/mcause/mtval driven from the latches; 0 in all other states.
//    - flush=1 and csr_w_kill=1. Next state is REDIRECT.
//  - REDIRECT, 1 cycle:
//    - redirect=1, flush=1.
//    - Trap: redirect_pc={mtvec[31:2],2'b00}. mret: redirect_pc=mepc_i (sampled this cycle).
//    - Next state is IDLE.
//  - Total latency from detect cycle T: is_trap/is_mret at T+1, redirect at T+2. The next event is accepted at T+3 at the earliest.
//  - Ignored inputs: event inputs in COMMIT/REDIRECT (flushed instructions). An interrupt seen then only sets int_pend.
//  - MIE=0: int_pend is held and not taken. Synchronous exceptions and mret are still taken.
//  - Simultaneous int_pend&MIE and an exception: the interrupt wins, exception flags are dropped, and int_pend is cleared.
//  - Bubble (valid_mem=0): no event is accepted, even if flags are set.
//  - redirect_pc holds its last value outside REDIRECT; consumers must gate it with redirect.
// TESTING
//  1. ecall_m at pc_mem=0x100, mtvec=0x205 -> T+1: is_trap=1, mcause=11, mepc=0x100, mtval=0, csr_w_kill=1. T+2: redirect=1, redirect_pc=0x204.
//  2. illegal_inst, inst_mem=0xFFFFFFFF, pc_mem=0x40 -> mcause=2, mtval=0xFFFFFFFF, mepc=0x40.
//  3. mret with mepc_i=0x104 -> T+1: is_mret=1, is_trap=0. T+2: redirect_pc=0x104. Then IDLE.
//  4. interrupt pulse while MIE=0, then MIE=1 with valid_mem=1, pc_mem=0x80 -> trap with mcause=0x8000000B, mepc=0x80. int_pend clears.
//  5. interrupt plus l_fault in the same cycle, MIE=1 -> mcause=0x8000000B only. An ecall in COMMIT/REDIRECT is ignored.
//  6. rst asserted in COMMIT -> all outputs 0 immediately, no redirect follows, and an ecall in the next cycle is accepted normally.

Source files
------------

// File: rtl/exception_unit.sv
// ============================================================================
//  Module      : exception_unit
//  Description : Trap/return sequencer for the machine-mode CSR file. It picks
//                one MEM-stage event by priority, pulses the CSR file, then
//                flushes the pipeline and redirects fetch.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module exception_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] INT_CAUSE = 32'h8000_000B
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mstatus,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc_i,
    input  logic        valid_mem,
    input  logic [31:0] pc_mem,
    input  logic [31:0] inst_mem,
    input  logic [31:0] addr_mem,
    input  logic        illegal_inst,
    input  logic        ecall_m,
    input  logic        l_fault,
    input  logic        s_fault,
    input  logic        mret,
    input  logic        interrupt,
    output logic        is_trap,
    output logic        is_mret,
    output logic [31:0] mepc,
    output logic [31:0] mcause,
    output logic [31:0] mtval,
    output logic        csr_w_kill,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    localparam logic [31:0] C_CAUSE_ILLEGAL = 32'd2;
    localparam logic [31:0] C_CAUSE_ECALL   = 32'd11;
    localparam logic [31:0] C_CAUSE_LFAULT  = 32'd5;
    localparam logic [31:0] C_CAUSE_SFAULT  = 32'd7;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COMMIT   = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        int_pend_q, int_pend_d;
    logic        kind_mret_q, kind_mret_d;
    logic        is_trap_q, is_trap_d;
    logic        is_mret_q, is_mret_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic        csr_w_kill_q, csr_w_kill_d;
    logic        flush_q, flush_d;
    logic        redirect_q, redirect_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic        w_take_int;
    logic        w_event;
    logic [31:0] w_target;

    assign w_take_int = int_pend_q & mstatus[3];
    assign w_event    = valid_mem & (w_take_int | illegal_inst | ecall_m |
                                     l_fault | s_fault | mret);
    // mepc_i and mtvec are sampled in the REDIRECT cycle itself
    assign w_target   = kind_mret_q ? mepc_i : {mtvec[31:2], 2'b00};

    always_comb begin
        state_d       = state_q;
        int_pend_d    = int_pend_q | interrupt;
        kind_mret_d   = kind_mret_q;
        is_trap_d     = 1'b0;
        is_mret_d     = 1'b0;
        mepc_d        = 32'd0;
        mcause_d      = 32'd0;
        mtval_d       = 32'd0;
        csr_w_kill_d  = 1'b0;
        flush_d       = 1'b0;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;

        case (state_q)
            S_IDLE: begin
                if (w_event) begin
                    state_d      = S_COMMIT;
                    csr_w_kill_d = 1'b1;
                    flush_d      = 1'b1;
                    kind_mret_d  = 1'b0;
                    is_trap_d    = 1'b1;
                    mepc_d       = pc_mem;
                    if (w_take_int) begin
                        mcause_d   = INT_CAUSE;
                        int_pend_d = 1'b0;
                    end else if (illegal_inst) begin
                        mcause_d = C_CAUSE_ILLEGAL;
                        mtval_d  = inst_mem;
                    end else if (ecall_m) begin
                        mcause_d = C_CAUSE_ECALL;
                    end else if (l_fault) begin
                        mcause_d = C_CAUSE_LFAULT;
                        mtval_d  = addr_mem;
                    end else if (s_fault) begin
                        mcause_d = C_CAUSE_SFAULT;
                        mtval_d  = addr_mem;
                    end else begin
                        kind_mret_d = 1'b1;
                        is_trap_d   = 1'b0;
                        is_mret_d   = 1'b1;
                        mepc_d      = 32'd0;
                    end
                end
            end
            S_COMMIT: begin
                state_d    = S_REDIRECT;
                redirect_d = 1'b1;
                flush_d    = 1'b1;
            end
            S_REDIRECT: begin
                state_d       = S_IDLE;
                redirect_pc_d = w_target;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            int_pend_q    <= 1'b0;
            kind_mret_q   <= 1'b0;
            is_trap_q     <= 1'b0;
            is_mret_q     <= 1'b0;
            mepc_q        <= 32'd0;
            mcause_q      <= 32'd0;
            mtval_q       <= 32'd0;
            csr_w_kill_q  <= 1'b0;
            flush_q       <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= RESET_PC;
        end else begin
            state_q       <= state_d;
            int_pend_q    <= int_pend_d;
            kind_mret_q   <= kind_mret_d;
            is_trap_q     <= is_trap_d;
            is_mret_q     <= is_mret_d;
            mepc_q        <= mepc_d;
            mcause_q      <= mcause_d;
            mtval_q       <= mtval_d;
            csr_w_kill_q  <= csr_w_kill_d;
            flush_q       <= flush_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign is_trap     = is_trap_q;
    assign is_mret     = is_mret_q;
    assign mepc        = mepc_q;
    assign mcause      = mcause_q;
    assign mtval       = mtval_q;
    assign csr_w_kill  = csr_w_kill_q;
    assign flush       = flush_q;
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_q ? w_target : redirect_pc_q;

endmodule

`default_nettype wire
